// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions (receiver and transmitter): FSM
//               state encoding, frame geometry, idle line level and the
//               default bit period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int   DATA_BITS            = 8;
  localparam logic IDLE_LEVEL           = 1'b1;
  localparam int   CLKS_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200 baud

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  // Even parity: the parity bit equals the XOR of the data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous input.
//               Both flops load RESET_VAL during synchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input to settle metastability.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : UART receiver, 8 data bits, LSB first, one stop bit.
//               Mid-bit sampling of a synchronized Rx line, single-entry
//               holding register with overrun detection, break handling.
//               Optional feature macro: UART_RX_PARITY_EN (adds an even
//               parity bit between the data and stop bits).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 Rx,
  input  logic                 RxRead,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  output logic                 RxDone,
  output logic                 FrameErr,
  output logic                 Overrun,
  output logic                 Busy,
  output logic                 ParityErr
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]        IDX_LAST  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 done_q;
  logic                 ferr_q;
  logic                 ovr_q;
  logic                 parity_bad;

  sync_2ff #(
    .RESET_VAL (IDLE_LEVEL)
  ) u_sync (
    .clk    (clk),
    .rst_ni (Reset),
    .d_i    (Rx),
    .q_o    (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic perr_q;
  logic pbad_q;
  assign parity_bad = pbad_q;
  assign ParityErr  = perr_q;
`else
  assign parity_bad = 1'b0;
  assign ParityErr  = 1'b0;
`endif

  // Receive FSM, holding register and all registered status outputs.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pbad_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      // A read only consumes a byte that is actually held.
      if (RxRead && valid_q) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (rx_s != IDLE_LEVEL) begin
            state_q <= ST_START;
          end
        end

        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            // A start bit that is high again at its centre is a glitch.
            state_q <= (rx_s == IDLE_LEVEL) ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST) begin
              idx_q   <= '0;
`ifdef UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            pbad_q  <= (rx_s != even_parity(shift_q));
            perr_q  <= (rx_s != even_parity(shift_q));
            state_q <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`endif

        ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s == IDLE_LEVEL) begin
              state_q <= ST_IDLE;
              if (!parity_bad) begin
                data_q  <= shift_q;
                done_q  <= 1'b1;
                valid_q <= 1'b1;
                // Overwriting an unread byte; a same-cycle read consumes it.
                if (valid_q && !RxRead) begin
                  ovr_q <= 1'b1;
                end
              end
            end else begin
              ferr_q  <= 1'b1;
              state_q <= ST_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        ST_BREAK: begin
          if (rx_s == IDLE_LEVEL) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign RxData   = data_q;
  assign RxValid  = valid_q;
  assign RxDone   = done_q;
  assign FrameErr = ferr_q;
  assign Overrun  = ovr_q;
  assign Busy     = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200 baud); legal range 8..65535.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-004 Rx  input  1  asynchronous serial line; idle high; 8N1 frame, LSB first.
REQ-005 RxRead  input  1  one-cycle read strobe from processor load path; consumes held byte.
REQ-006 RxData  output  8  last correctly framed byte.
REQ-007 RxValid  output  1  RxData holds an unread byte.
REQ-008 RxDone  output  1  one-cycle pulse when a byte is written to RxData.
REQ-009 FrameErr  output  1  one-cycle pulse on stop bit sampled low.
REQ-010 Overrun  output  1  sticky; unread byte was overwritten.
REQ-011 Busy  output  1  high in every state other than IDLE.
REQ-012 ParityErr  output  1  one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.

Function
REQ-013 Rx SHALL pass through a two-flop synchronizer before any use; all sampling uses the synchronized value.
REQ-014 FSM states: IDLE, START, DATA, PARITY (only when enabled), STOP, BREAK.
REQ-015 IDLE: synchronized Rx == 0 -> START; bit counter and bit index cleared.
REQ-016 START: at count CLKS_PER_BIT/2 - 1 (integer division), sample Rx; 0 -> DATA with counter cleared; 1 -> IDLE, glitch rejected, no output pulses.
REQ-017 DATA: sample at each count CLKS_PER_BIT - 1 (mid-bit), shift in LSB first; after the 8th sample -> PARITY if enabled, else STOP.
REQ-018 STOP: sample at count CLKS_PER_BIT - 1; 1 with no parity error -> commit; 0 -> FrameErr pulse, byte discarded, -> BREAK.
REQ-019 Commit: RxData <= shifted byte, RxDone pulse, RxValid <= 1, -> IDLE in the same cycle.
REQ-020 BREAK: remain until synchronized Rx == 1, then -> IDLE; a held-low line SHALL produce exactly one FrameErr.
REQ-021 Latency: RxDone asserts 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (+CLKS_PER_BIT with parity) after the first clk edge at which Rx is low, +/-1 cycle.
REQ-022 RxRead with RxValid == 1 clears RxValid and Overrun on the next edge; RxRead with RxValid == 0 has no effect.
REQ-023 Commit while RxValid == 1 and RxRead == 0: RxData overwritten, Overrun <= 1, RxValid stays 1.
REQ-024 Commit and RxRead in the same cycle: new byte held, RxValid stays 1, Overrun not set.
REQ-025 Bit counter width SHALL be $clog2(CLKS_PER_BIT); no counter wraps except by explicit clear.

Reset
REQ-026 Reset == 0: FSM -> IDLE; counters, shift register and RxData = 0x00; RxValid, RxDone, FrameErr, ParityErr, Overrun, Busy = 0; synchronizer flops = 1.
REQ-027 Reset mid-frame SHALL abandon the frame with no output pulse; reception resumes at the next falling edge after release.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: PARITY state samples a 9th (even parity) bit; mismatch -> ParityErr pulse, byte discarded, STOP still sampled and its FrameErr rule still applies.
REQ-029 Macro UART_RX_PARITY_EN undefined: no PARITY state, ParityErr tied 0, frame is 8N1.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum, DATA_BITS = 8, IDLE_LEVEL = 1'b1 and the default CLKS_PER_BIT; this package is shared with the transmitter.
REQ-031 The synchronizer SHALL be a separate sub-module, sync_2ff.

Verification (CLKS_PER_BIT = 16)
REQ-032 Frame 0x55, stop bit 1, RxRead idle -> one RxDone pulse, RxData = 0x55, RxValid = 1, FrameErr = 0.
REQ-033 Rx low for 6 cycles, then high -> no RxDone, FSM back in IDLE, Busy low within 10 cycles.
REQ-034 Frames 0xA3 then 0x3C, no RxRead -> RxData = 0x3C, Overrun = 1; single RxRead -> RxValid = 0, Overrun = 0.
REQ-035 Frame 0xFF with stop bit 0, Rx held low for 40 bit times -> exactly one FrameErr, RxValid unchanged, no further pulses until the line returns high.
REQ-036 Reset driven low at data bit 4 of 0x81 -> all outputs 0; next frame 0x81 received intact.
REQ-037 With UART_RX_PARITY_EN defined, frame 0x07 with parity bit 0 -> ParityErr pulse, no RxDone; with parity bit 1 -> RxData = 0x07.
